// File: rtl/if_fetch.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Keeps one request/acknowledge transaction to instruction memory in flight
// and presents the returned word with its PC. It supports variable memory
// latency, a one-entry skid for downstream stalls, delay-slot branch
// redirects, exception flushes that kill an in-flight request, and a
// watchdog that re-presents a request which is never acknowledged.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        imem_ce_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        misalign_exc_o,
    output logic        fetch_err_o
);

    // Fetch sequencer states
    localparam logic [1:0] IDLE = 2'd0;  // first cycle after reset, nothing in flight
    localparam logic [1:0] WAIT = 2'd1;  // request outstanding, response will be used
    localparam logic [1:0] FULL = 2'd2;  // response parked in skid, waiting for stall release
    localparam logic [1:0] DROP = 2'd3;  // killed request outstanding, response will be discarded

    // Watchdog counter is sized to hold TIMEOUT; a zero TIMEOUT disables it
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    state_q,     state_d;
    logic          ce_q,        ce_d;
    logic [31:0]   addr_q,      addr_d;
    logic [31:0]   pc_q,        pc_d;
    logic [31:0]   inst_q,      inst_d;
    logic          valid_q,     valid_d;
    logic          misalign_q,  misalign_d;
    logic          err_q,       err_d;
    logic          redir_v_q,   redir_v_d;
    logic [31:0]   redir_pc_q,  redir_pc_d;
    logic [31:0]   skid_pc_q,   skid_pc_d;
    logic [31:0]   skid_inst_q, skid_inst_d;
    logic [31:0]   drop_pc_q,   drop_pc_d;
    logic [CW-1:0] cnt_q,       cnt_d;

    logic          outstanding;
    logic          branch_ok;
    logic          branch_bad;
    logic          timeout_hit;
    logic          issue;
    logic [31:0]   seq_addr;
    logic [31:0]   issue_addr;

    // Classify the branch strobe and work out where the next request should go
    always_comb begin
        outstanding = (state_q == WAIT) || (state_q == DROP);
        branch_ok   = branch_flag_i && (branch_target_i[1:0] == 2'b00);
        branch_bad  = branch_flag_i && (branch_target_i[1:0] != 2'b00);
        timeout_hit = (TIMEOUT != 0) && outstanding && !imem_ack_i && (cnt_q == CNT_LAST);
        if (state_q == IDLE) begin
            seq_addr = RESET_PC;
        end else if (redir_v_q) begin
            seq_addr = redir_pc_q;
        end else begin
            seq_addr = addr_q + 32'd4;
        end
        issue_addr = branch_ok ? branch_target_i : seq_addr;
    end

    // Next-state logic: flush dominates, then the per-state request/response handling,
    // then branch bookkeeping and issuing of the following request
    always_comb begin
        state_d     = state_q;
        ce_d        = ce_q;
        addr_d      = addr_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        misalign_d  = 1'b0;
        err_d       = timeout_hit;
        redir_v_d   = redir_v_q;
        redir_pc_d  = redir_pc_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        drop_pc_d   = drop_pc_q;
        issue       = 1'b0;

        if (outstanding && !imem_ack_i) begin
            cnt_d = timeout_hit ? '0 : cnt_q + CNT_ONE;
        end else begin
            cnt_d = '0;
        end

        if (flush_i) begin
            redir_v_d   = 1'b0;
            skid_pc_d   = 32'd0;
            skid_inst_d = 32'd0;
            valid_d     = 1'b0;
            inst_d      = 32'd0;
            if (!outstanding || imem_ack_i) begin
                ce_d    = 1'b1;
                addr_d  = flush_pc_i;
                state_d = WAIT;
                cnt_d   = '0;
            end else begin
                drop_pc_d = flush_pc_i;
                state_d   = DROP;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    issue = 1'b1;
                end
                WAIT: begin
                    if (imem_ack_i) begin
                        if (!stall_i) begin
                            pc_d    = addr_q;
                            inst_d  = imem_rdata_i;
                            valid_d = 1'b1;
                            issue   = 1'b1;
                        end else begin
                            skid_pc_d   = addr_q;
                            skid_inst_d = imem_rdata_i;
                            ce_d        = 1'b0;
                            state_d     = FULL;
                        end
                    end else if (!stall_i) begin
                        valid_d = 1'b0;
                        inst_d  = 32'd0;
                    end
                end
                FULL: begin
                    if (!stall_i) begin
                        pc_d    = skid_pc_q;
                        inst_d  = skid_inst_q;
                        valid_d = 1'b1;
                        issue   = 1'b1;
                    end
                end
                default: begin
                    if (imem_ack_i) begin
                        ce_d    = 1'b1;
                        addr_d  = drop_pc_q;
                        state_d = WAIT;
                    end
                end
            endcase

            if (state_q != DROP) begin
                misalign_d = branch_bad;
                if (branch_ok && !issue) begin
                    redir_v_d  = 1'b1;
                    redir_pc_d = branch_target_i;
                end
            end

            if (issue) begin
                ce_d      = 1'b1;
                addr_d    = issue_addr;
                state_d   = WAIT;
                redir_v_d = 1'b0;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ce_q        <= 1'b0;
            addr_q      <= RESET_PC;
            pc_q        <= 32'd0;
            inst_q      <= 32'd0;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
            err_q       <= 1'b0;
            redir_v_q   <= 1'b0;
            redir_pc_q  <= 32'd0;
            skid_pc_q   <= 32'd0;
            skid_inst_q <= 32'd0;
            drop_pc_q   <= 32'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ce_q        <= ce_d;
            addr_q      <= addr_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
            misalign_q  <= misalign_d;
            err_q       <= err_d;
            redir_v_q   <= redir_v_d;
            redir_pc_q  <= redir_pc_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            drop_pc_q   <= drop_pc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign imem_ce_o      = ce_q;
    assign imem_addr_o    = addr_q;
    assign if_pc_o        = pc_q;
    assign if_inst_o      = inst_q;
    assign if_valid_o     = valid_q;
    assign misalign_exc_o = misalign_q;
    assign fetch_err_o    = err_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a linear sequence of one-cycle steps, each
// followed by immediate assertions against hand-computed expected values.
// Memory responses carry the word (address + 0x1000_0000).
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branchFlag;
    logic [31:0] branchTarget;
    logic        flush;
    logic [31:0] flushPc;
    logic        imemCe;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic [31:0] ifPc;
    logic [31:0] ifInst;
    logic        ifValid;
    logic        misalignExc;
    logic        fetchErr;

    int compareCount = 0;
    int failCount    = 0;

    if_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .branch_flag_i   (branchFlag),
        .branch_target_i (branchTarget),
        .flush_i         (flush),
        .flush_pc_i      (flushPc),
        .imem_ce_o       (imemCe),
        .imem_addr_o     (imemAddr),
        .imem_ack_i      (imemAck),
        .imem_rdata_i    (imemRdata),
        .if_pc_o         (ifPc),
        .if_inst_o       (ifInst),
        .if_valid_o      (ifValid),
        .misalign_exc_o  (misalignExc),
        .fetch_err_o     (fetchErr)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs, then advance to just after the next rising edge
    task automatic applyStimulus(input logic ack, input logic [31:0] ackAddr, input logic stl,
                                 input logic br, input logic [31:0] brTarget,
                                 input logic fl, input logic [31:0] flPc);
        imemAck      = ack;
        imemRdata    = ack ? (ackAddr + 32'h1000_0000) : 32'd0;
        stall        = stl;
        branchFlag   = br;
        branchTarget = brTarget;
        flush        = fl;
        flushPc      = flPc;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Check the full presented-instruction triple
    task automatic checkPresent(input string tag, input logic [31:0] pc, input logic [31:0] inst, input logic valid);
        checkOutput({tag, ".pc"}, ifPc, pc);
        checkOutput({tag, ".inst"}, ifInst, inst);
        checkOutput({tag, ".valid"}, {31'd0, ifValid}, {31'd0, valid});
    endtask

    // Check the memory request port
    task automatic checkRequest(input string tag, input logic ce, input logic [31:0] addr);
        checkOutput({tag, ".ce"}, {31'd0, imemCe}, {31'd0, ce});
        checkOutput({tag, ".addr"}, imemAddr, addr);
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        branchFlag   = 1'b0;
        branchTarget = 32'd0;
        flush        = 1'b0;
        flushPc      = 32'd0;
        imemAck      = 1'b0;
        imemRdata    = 32'd0;

        $display("[TB] reset");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkRequest("rst", 1'b0, 32'h0);
        checkPresent("rst", 32'h0, 32'h0, 1'b0);
        checkOutput("rst.misalign", {31'd0, misalignExc}, 32'd0);
        checkOutput("rst.ferr", {31'd0, fetchErr}, 32'd0);

        $display("[TB] back-to-back fetch");
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkRequest("idle", 1'b1, 32'h0);
        checkPresent("idle", 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("b2b0", 32'h0, 32'h1000_0000, 1'b1);
        checkRequest("b2b0", 1'b1, 32'h4);
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("b2b4", 32'h4, 32'h1000_0004, 1'b1);
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("b2b8", 32'h8, 32'h1000_0008, 1'b1);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("b2bC", 32'hC, 32'h1000_000C, 1'b1);
        checkRequest("b2bC", 1'b1, 32'h10);

        $display("[TB] latency 3");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("lat1", 32'hC, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("lat2", 32'hC, 32'h0, 1'b0);
        checkRequest("lat2", 1'b1, 32'h10);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("lat3", 32'h10, 32'h1000_0010, 1'b1);

        $display("[TB] stall with skid");
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("st0", 32'h14, 32'h1000_0014, 1'b1);
        checkRequest("st0", 1'b1, 32'h18);
        applyStimulus(1'b1, 32'h18, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("st1", 32'h14, 32'h1000_0014, 1'b1);
        checkRequest("st1", 1'b0, 32'h18);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        end
        checkPresent("st4", 32'h14, 32'h1000_0014, 1'b1);
        checkOutput("st4.ce", {31'd0, imemCe}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("strel", 32'h18, 32'h1000_0018, 1'b1);
        checkRequest("strel", 1'b1, 32'h1C);

        $display("[TB] branch and misalign");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, 32'd0);
        checkRequest("br0", 1'b1, 32'h1C);
        applyStimulus(1'b1, 32'h1C, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("brslot", 32'h1C, 32'h1000_001C, 1'b1);
        checkRequest("brtgt", 1'b1, 32'h100);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 32'h102, 1'b0, 32'd0);
        checkPresent("mis", 32'h100, 32'h1000_0100, 1'b1);
        checkOutput("mis.pulse", {31'd0, misalignExc}, 32'd1);
        checkRequest("mis", 1'b1, 32'h104);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("mis.end", {31'd0, misalignExc}, 32'd0);
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0);
        checkPresent("brsame", 32'h104, 32'h1000_0104, 1'b1);
        checkRequest("brsame", 1'b1, 32'h200);

        $display("[TB] flush");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h180);
        checkPresent("fl0", 32'h104, 32'h0, 1'b0);
        checkRequest("fl0", 1'b1, 32'h200);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkRequest("fl1", 1'b1, 32'h200);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("fldrop.valid", {31'd0, ifValid}, 32'd0);
        checkRequest("fldrop", 1'b1, 32'h180);
        applyStimulus(1'b1, 32'h180, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("flh", 32'h180, 32'h1000_0180, 1'b1);
        checkRequest("flh", 1'b1, 32'h184);

        $display("[TB] flush with ack and address wrap");
        applyStimulus(1'b1, 32'h184, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        checkOutput("flack.valid", {31'd0, ifValid}, 32'd0);
        checkRequest("flack", 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("wrap", 32'hFFFF_FFFC, 32'h0FFF_FFFC, 1'b1);
        checkRequest("wrap", 1'b1, 32'h0);

        $display("[TB] timeout");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            checkOutput("to.quiet", {31'd0, fetchErr}, 32'd0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("to.pulse", {31'd0, fetchErr}, 32'd1);
        checkRequest("to.pulse", 1'b1, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("to.end", {31'd0, fetchErr}, 32'd0);

        $display("[TB] reset mid-request");
        rst = 1'b1;
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkRequest("rst2", 1'b0, 32'h0);
        checkPresent("rst2", 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkRequest("rst2idle", 1'b1, 32'h0);
        checkOutput("rst2idle.valid", {31'd0, ifValid}, 32'd0);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkPresent("rst2first", 32'h0, 32'h1000_0000, 1'b1);
        checkRequest("rst2first", 1'b1, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
